// File: rtl/mc_main_fsm_v2.sv
// mc_main_fsm_v2 - multicycle RV32I main controller.
//
// Sequences fetch, decode, execute, memory and writeback for the multicycle
// datapath. Adds a memory wait-state handshake with timeout, in-block branch
// resolution, an optional multi-cycle MUL/DIV handshake and a sticky trap.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   op/funct3/funct7    instruction fields from the IR
//   zero, neg           ALU flags of the current-cycle ALU result
//   mem_ready           memory completes the access this cycle
//   md_done             mul/div result valid pulse
//   resultSrc, ALUSrcA, ALUSrcB, ALUOp, immSrc, adrSrc  datapath mux selects
//   mem_req, memWrite, IRWrite, regWrite, pc_write, md_start, md_sel  enables
//   trap, trap_cause    sticky trap flag and cause (01 illegal op, 10 bus timeout)
//   state_o             current state, debug only
//
// State table
//   S_IF      | fetch, wait for mem_ready, write IR and PC+4
//   S_ID      | decode, compute branch target into ALUOut
//   S_EX_I    | ALU op rs1, imm
//   S_EX_R    | ALU op rs1, rs2
//   S_EX_MD   | wait for the mul/div unit
//   S_WB_MD   | write mul/div result
//   S_WB_ALU  | write ALUOut to rd
//   S_EX_B    | compare, conditionally load branch target
//   S_EX_J    | compute PC+4 for the link value
//   S_WB_J    | write link, compute jump target
//   S_PC_J    | load jump target into PC
//   S_EX_JALR | compute rs1+imm
//   S_PC_JALR | load JALR target, compute link value
//   S_EX_LW   | compute load address
//   S_MEM_LW  | load access, wait for mem_ready
//   S_WB_LW   | write load data
//   S_EX_S    | compute store address
//   S_MEM_S   | store access, wait for mem_ready
//   S_U       | write immediate (LUI)
//   S_TRAP    | halted until reset

module mc_main_fsm_v2 #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned TO_W          = 8,
    parameter bit          EN_MULDIV     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       neg,
    input  logic       mem_ready,
    input  logic       md_done,
    output logic [1:0] resultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] immSrc,
    output logic       adrSrc,
    output logic       mem_req,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       regWrite,
    output logic       pc_write,
    output logic       md_start,
    output logic       md_sel,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [4:0] state_o
);

    typedef enum logic [4:0] {
        S_IF      = 5'd0,
        S_ID      = 5'd1,
        S_EX_I    = 5'd2,
        S_EX_R    = 5'd3,
        S_EX_MD   = 5'd4,
        S_WB_MD   = 5'd5,
        S_WB_ALU  = 5'd6,
        S_EX_B    = 5'd7,
        S_EX_J    = 5'd8,
        S_WB_J    = 5'd9,
        S_PC_J    = 5'd10,
        S_EX_JALR = 5'd11,
        S_PC_JALR = 5'd12,
        S_EX_LW   = 5'd13,
        S_MEM_LW  = 5'd14,
        S_WB_LW   = 5'd15,
        S_EX_S    = 5'd16,
        S_MEM_S   = 5'd17,
        S_U       = 5'd18,
        S_TRAP    = 5'd19
    } state_t;

    // Moore part of the control word, registered from the next state.
    typedef struct packed {
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
        logic       adr_src;
        logic       mem_req;
        logic       reg_write;
        logic       pc_write;
        logic       md_sel;
    } ctrl_t;

    localparam bit             TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] wait_cnt;
    logic            trap_q;
    logic [1:0]      cause_q;
    logic [1:0]      cause_nxt;
    ctrl_t           ctrl_q;
    logic            md_start_q;
    logic            ready_eff;
    logic            in_wait;
    logic            timed_out;
    logic            taken;

    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_IF:      begin c.mem_req = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10; end
            S_ID:      begin c.src_a = 2'b01; c.src_b = 2'b01; c.imm_src = 3'b010; end
            S_EX_I:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b11; end
            S_EX_R:    begin c.src_a = 2'b10; c.alu_op = 2'b10; end
            S_WB_MD:   begin c.reg_write = 1'b1; c.md_sel = 1'b1; end
            S_WB_ALU:  c.reg_write = 1'b1;
            S_EX_B:    begin c.src_a = 2'b10; c.alu_op = 2'b01; end
            S_EX_J:    begin c.src_a = 2'b01; c.src_b = 2'b10; end
            S_WB_J:    begin
                c.reg_write = 1'b1;
                c.src_a     = 2'b01;
                c.src_b     = 2'b01;
                c.imm_src   = 3'b011;
            end
            S_PC_J:    c.pc_write = 1'b1;
            S_EX_JALR: begin c.src_a = 2'b10; c.src_b = 2'b01; end
            S_PC_JALR: begin c.pc_write = 1'b1; c.src_a = 2'b01; c.src_b = 2'b10; end
            S_EX_LW:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
            S_MEM_LW:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            S_WB_LW:   begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            S_EX_S:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.imm_src = 3'b001; end
            S_MEM_S:   begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            S_U:       begin c.result_src = 2'b11; c.imm_src = 3'b100; c.reg_write = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    assign ready_eff = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign in_wait   = (state == S_IF) || (state == S_MEM_LW) || (state == S_MEM_S);
    // Trap on the wait cycle that would bring the counter up to TIMEOUT.
    assign timed_out = TO_EN && in_wait && !ready_eff && (wait_cnt == TO_LAST);

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = neg;
            3'b101:  taken = ~neg;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = 2'b00;
        case (state)
            S_IF: begin
                if (timed_out) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'b10;
                end else if (ready_eff) begin
                    state_nxt = S_ID;
                end
            end
            S_ID: begin
                case (op)
                    7'b0010011: state_nxt = S_EX_I;
                    7'b0110011: state_nxt = S_EX_R;
                    7'b1100011: state_nxt = S_EX_B;
                    7'b1101111: state_nxt = S_EX_J;
                    7'b1100111: state_nxt = S_EX_JALR;
                    7'b0000011: state_nxt = S_EX_LW;
                    7'b0100011: state_nxt = S_EX_S;
                    7'b0110111: state_nxt = S_U;
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = 2'b01;
                    end
                endcase
            end
            S_EX_I:    state_nxt = S_WB_ALU;
            S_EX_R:    state_nxt = (EN_MULDIV && (funct7 == 7'b0000001)) ? S_EX_MD : S_WB_ALU;
            S_EX_MD:   if (md_done) state_nxt = S_WB_MD;
            S_WB_MD:   state_nxt = S_IF;
            S_WB_ALU:  state_nxt = S_IF;
            S_EX_B:    state_nxt = S_IF;
            S_EX_J:    state_nxt = S_WB_J;
            S_WB_J:    state_nxt = S_PC_J;
            S_PC_J:    state_nxt = S_IF;
            S_EX_JALR: state_nxt = S_PC_JALR;
            S_PC_JALR: state_nxt = S_WB_ALU;
            S_EX_LW:   state_nxt = S_MEM_LW;
            S_MEM_LW: begin
                if (timed_out) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'b10;
                end else if (ready_eff) begin
                    state_nxt = S_WB_LW;
                end
            end
            S_WB_LW:   state_nxt = S_IF;
            S_EX_S:    state_nxt = S_MEM_S;
            S_MEM_S: begin
                if (timed_out) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'b10;
                end else if (ready_eff) begin
                    state_nxt = S_IF;
                end
            end
            S_U:       state_nxt = S_IF;
            S_TRAP:    state_nxt = S_TRAP;
            default:   state_nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IF;
            wait_cnt   <= '0;
            trap_q     <= 1'b0;
            cause_q    <= 2'b00;
            ctrl_q     <= moore_ctrl(S_IF);
            md_start_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (in_wait && !ready_eff) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end
            if ((state_nxt == S_TRAP) && (state != S_TRAP)) begin
                trap_q  <= 1'b1;
                cause_q <= cause_nxt;
            end
            ctrl_q     <= moore_ctrl(state_nxt);
            md_start_q <= (state_nxt == S_EX_MD) && (state != S_EX_MD);
        end
    end

    // Every output is gated by rst_n so an asserted reset silences the block
    // immediately, even mid-wait. Mealy terms are gated by the current state.
    assign resultSrc  = rst_n ? ctrl_q.result_src : 2'b00;
    assign ALUSrcA    = rst_n ? ctrl_q.src_a      : 2'b00;
    assign ALUSrcB    = rst_n ? ctrl_q.src_b      : 2'b00;
    assign ALUOp      = rst_n ? ctrl_q.alu_op     : 2'b00;
    assign immSrc     = rst_n ? ctrl_q.imm_src    : 3'b000;
    assign adrSrc     = rst_n & ctrl_q.adr_src;
    assign mem_req    = rst_n & ctrl_q.mem_req;
    assign regWrite   = rst_n & ctrl_q.reg_write;
    assign md_sel     = rst_n & ctrl_q.md_sel;
    assign md_start   = rst_n & md_start_q;
    assign IRWrite    = rst_n & (state == S_IF) & ready_eff;
    assign memWrite   = rst_n & (state == S_MEM_S) & ready_eff;
    assign pc_write   = rst_n & (ctrl_q.pc_write
                                 | ((state == S_IF) & ready_eff)
                                 | ((state == S_EX_B) & taken));
    assign trap       = rst_n & trap_q;
    assign trap_cause = rst_n ? cause_q : 2'b00;
    assign state_o    = rst_n ? state : 5'd0;

endmodule

// File: tb/tb_mc_main_fsm_v2.sv
// Bench for mc_main_fsm_v2: two instances (A: handshake, TIMEOUT=4, muldiv;
// B: no handshake, no timeout, no muldiv) share stimulus. The reference is a
// per-instruction list of pipeline phases with per-phase expected outputs.
module tb_mc_main_fsm_v2;

    localparam int P_IF = 0, P_ID = 1, P_EX_I = 2, P_EX_R = 3, P_EX_MD = 4;
    localparam int P_WB_MD = 5, P_WB_ALU = 6, P_EX_B = 7, P_EX_J = 8, P_WB_J = 9;
    localparam int P_PC_J = 10, P_EX_JALR = 11, P_PC_JALR = 12, P_EX_LW = 13;
    localparam int P_MEM_LW = 14, P_WB_LW = 15, P_EX_S = 16, P_MEM_S = 17;
    localparam int P_U = 18, P_TRAP = 19;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero, neg, mem_ready, md_done;

    logic [1:0] rs_a, sa_a, sb_a, ao_a, tc_a, rs_b, sa_b, sb_b, ao_b, tc_b;
    logic [2:0] im_a, im_b;
    logic       ad_a, mr_a, mw_a, ir_a, rw_a, pw_a, ms_a, md_a, tr_a;
    logic       ad_b, mr_b, mw_b, ir_b, rw_b, pw_b, ms_b, md_b, tr_b;
    logic [4:0] st_a, st_b;
    logic [21:0] vec_a, vec_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit sel;
    bit cfg_hs, cfg_md;
    int cfg_to;

    logic [6:0] legal_ops [8] = '{7'b0010011, 7'b0110011, 7'b1100011, 7'b1101111,
                                  7'b1100111, 7'b0000011, 7'b0100011, 7'b0110111};

    always #5 clk = ~clk;

    mc_main_fsm_v2 #(.MEM_HANDSHAKE(1'b1), .TIMEOUT(4), .TO_W(3), .EN_MULDIV(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .neg(neg), .mem_ready(mem_ready), .md_done(md_done),
        .resultSrc(rs_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ALUOp(ao_a), .immSrc(im_a),
        .adrSrc(ad_a), .mem_req(mr_a), .memWrite(mw_a), .IRWrite(ir_a), .regWrite(rw_a),
        .pc_write(pw_a), .md_start(ms_a), .md_sel(md_a), .trap(tr_a), .trap_cause(tc_a),
        .state_o(st_a));

    mc_main_fsm_v2 #(.MEM_HANDSHAKE(1'b0), .TIMEOUT(0), .TO_W(8), .EN_MULDIV(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .neg(neg), .mem_ready(mem_ready), .md_done(md_done),
        .resultSrc(rs_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ALUOp(ao_b), .immSrc(im_b),
        .adrSrc(ad_b), .mem_req(mr_b), .memWrite(mw_b), .IRWrite(ir_b), .regWrite(rw_b),
        .pc_write(pw_b), .md_start(ms_b), .md_sel(md_b), .trap(tr_b), .trap_cause(tc_b),
        .state_o(st_b));

    assign vec_a = {tr_a, tc_a, rs_a, sa_a, sb_a, ao_a, im_a,
                    ad_a, mr_a, mw_a, ir_a, rw_a, pw_a, ms_a, md_a};
    assign vec_b = {tr_b, tc_b, rs_b, sa_b, sb_b, ao_b, im_b,
                    ad_b, mr_b, mw_b, ir_b, rw_b, pw_b, ms_b, md_b};

    // Expected outputs for one cycle of a phase, straight from the phase table.
    function automatic logic [21:0] exp_vec(input int p, input bit rdy, input bit tk,
                                            input bit entry, input logic [1:0] cause);
        logic [1:0] rs, a, b, aop, co;
        logic [2:0] imm;
        logic adr, mreq, mw, irw, rw, pcw, mds, mdsel, tr;
        {rs, a, b, aop, co, imm} = '0;
        {adr, mreq, mw, irw, rw, pcw, mds, mdsel, tr} = '0;
        case (p)
            P_IF:      begin mreq = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            P_ID:      begin a = 2'b01; b = 2'b01; imm = 3'b010; end
            P_EX_I:    begin a = 2'b10; b = 2'b01; aop = 2'b11; end
            P_EX_R:    begin a = 2'b10; aop = 2'b10; end
            P_EX_MD:   mds = entry;
            P_WB_MD:   begin rw = 1; mdsel = 1; end
            P_WB_ALU:  rw = 1;
            P_EX_B:    begin a = 2'b10; aop = 2'b01; pcw = tk; end
            P_EX_J:    begin a = 2'b01; b = 2'b10; end
            P_WB_J:    begin rw = 1; a = 2'b01; b = 2'b01; imm = 3'b011; end
            P_PC_J:    pcw = 1;
            P_EX_JALR: begin a = 2'b10; b = 2'b01; end
            P_PC_JALR: begin pcw = 1; a = 2'b01; b = 2'b10; end
            P_EX_LW:   begin a = 2'b10; b = 2'b01; end
            P_MEM_LW:  begin mreq = 1; adr = 1; end
            P_WB_LW:   begin rs = 2'b01; rw = 1; end
            P_EX_S:    begin a = 2'b10; b = 2'b01; imm = 3'b001; end
            P_MEM_S:   begin mreq = 1; adr = 1; mw = rdy; end
            P_U:       begin rs = 2'b11; imm = 3'b100; rw = 1; end
            P_TRAP:    begin tr = 1; co = cause; end
            default:   ;
        endcase
        return {tr, co, rs, a, b, aop, imm, adr, mreq, mw, irw, rw, pcw, mds, mdsel};
    endfunction

    function automatic bit branch_taken(input logic [2:0] f3, input bit z, input bit n);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return n;
            3'd5:    return !n;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_cfg(input bit s);
        sel    = s;
        cfg_hs = !s;
        cfg_to = s ? 0 : 4;
        cfg_md = !s;
    endtask

    task automatic step(input logic [21:0] exp, input string tag);
        logic [21:0] obs;
        #1;
        obs = sel ? vec_b : vec_a;
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        n_checks++;
        assert ({vec_a, st_a} === 27'd0) else begin
            n_fail++;
            $error("FAIL %s_a: observed %07h expected 0", tag, {vec_a, st_a});
        end
        n_checks++;
        assert ({vec_b, st_b} === 27'd0) else begin
            n_fail++;
            $error("FAIL %s_b: observed %07h expected 0", tag, {vec_b, st_b});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one instruction from fetch to its last phase, checking every cycle.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                             input bit z, input bit n, input int w_if, input int w_mem,
                             input int md_lat, input int trap_cycles, input string tag,
                             output bit trapped);
        int ph[$];
        int w;
        bit tk;
        logic [1:0] cause;
        op = o; funct3 = f3; funct7 = f7; zero = z; neg = n;
        tk = branch_taken(f3, z, n);
        trapped = 1'b0;
        cause = 2'b00;
        ph.push_back(P_IF);
        ph.push_back(P_ID);
        case (o)
            7'b0010011: begin ph.push_back(P_EX_I); ph.push_back(P_WB_ALU); end
            7'b0110011: begin
                ph.push_back(P_EX_R);
                if (cfg_md && f7 == 7'b0000001) begin
                    ph.push_back(P_EX_MD); ph.push_back(P_WB_MD);
                end else begin
                    ph.push_back(P_WB_ALU);
                end
            end
            7'b1100011: ph.push_back(P_EX_B);
            7'b1101111: begin ph.push_back(P_EX_J); ph.push_back(P_WB_J); ph.push_back(P_PC_J); end
            7'b1100111: begin
                ph.push_back(P_EX_JALR); ph.push_back(P_PC_JALR); ph.push_back(P_WB_ALU);
            end
            7'b0000011: begin ph.push_back(P_EX_LW); ph.push_back(P_MEM_LW); ph.push_back(P_WB_LW); end
            7'b0100011: begin ph.push_back(P_EX_S); ph.push_back(P_MEM_S); end
            7'b0110111: ph.push_back(P_U);
            default: cause = 2'b01;
        endcase
        for (int i = 0; i < ph.size() && !trapped; i++) begin
            if (ph[i] == P_IF || ph[i] == P_MEM_LW || ph[i] == P_MEM_S) begin
                w = (ph[i] == P_IF) ? w_if : w_mem;
                if (!cfg_hs) w = 0;
                if (cfg_to != 0 && w >= cfg_to) begin
                    for (int k = 0; k < cfg_to; k++) begin
                        mem_ready = 1'b0; md_done = 1'($urandom_range(0, 1));
                        step(exp_vec(ph[i], 1'b0, tk, 1'b0, 2'b00), tag);
                    end
                    trapped = 1'b1;
                    cause = 2'b10;
                end else begin
                    for (int k = 0; k <= w; k++) begin
                        mem_ready = cfg_hs ? (k == w) : 1'($urandom_range(0, 1));
                        md_done = 1'($urandom_range(0, 1));
                        step(exp_vec(ph[i], k == w, tk, 1'b0, 2'b00), tag);
                    end
                end
            end else if (ph[i] == P_EX_MD) begin
                for (int k = 1; k <= md_lat; k++) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    md_done = (k == md_lat);
                    step(exp_vec(P_EX_MD, 1'b1, tk, k == 1, 2'b00), tag);
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                md_done = 1'($urandom_range(0, 1));
                step(exp_vec(ph[i], 1'b1, tk, 1'b0, 2'b00), tag);
            end
        end
        if (cause == 2'b01) trapped = 1'b1;
        if (trapped) begin
            for (int k = 0; k < trap_cycles; k++) begin
                mem_ready = 1'($urandom_range(0, 1));
                md_done = 1'($urandom_range(0, 1));
                op = 7'($urandom);
                step(exp_vec(P_TRAP, 1'b0, 1'b0, 1'b0, cause), {tag, "_trap"});
            end
        end
        md_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit tp;
        op = 7'b0010011; funct3 = 3'd0; funct7 = 7'd0;
        zero = 1'b0; neg = 1'b0; mem_ready = 1'b0; md_done = 1'b0;
        set_cfg(1'b0);
        do_reset("reset_init");

        // Instance B: no handshake, no muldiv.
        set_cfg(1'b1);
        run_instr(7'b0010011, 3'd0, 7'd0, 0, 0, 0, 0, 1, 2, "addi_nohs", tp);
        run_instr(7'b0110011, 3'd0, 7'b0000001, 0, 0, 0, 0, 1, 2, "mul_nomd", tp);
        run_instr(7'b0000011, 3'd2, 7'd0, 0, 0, 3, 3, 1, 2, "lw_nohs", tp);
        run_instr(7'b0100011, 3'd2, 7'd0, 0, 0, 2, 2, 1, 2, "sw_nohs", tp);

        // Instance A: handshake, TIMEOUT=4, muldiv.
        set_cfg(1'b0);
        do_reset("reset_a");
        run_instr(7'b0000011, 3'd2, 7'd0, 0, 0, 0, 3, 1, 2, "lw_wait3", tp);
        run_instr(7'b1100011, 3'd0, 7'd0, 1, 0, 1, 0, 1, 2, "beq_z1", tp);
        run_instr(7'b1100011, 3'd1, 7'd0, 1, 0, 0, 0, 1, 2, "bne_z1", tp);
        run_instr(7'b1100011, 3'd4, 7'd0, 0, 1, 0, 0, 1, 2, "blt_n1", tp);
        run_instr(7'b1100011, 3'd6, 7'd0, 1, 1, 0, 0, 1, 2, "bltu_nt", tp);
        run_instr(7'b0110011, 3'd0, 7'b0000001, 0, 0, 0, 0, 6, 2, "mul_md6", tp);
        run_instr(7'b0100011, 3'd2, 7'd0, 0, 0, 3, 3, 1, 2, "sw_wait", tp);
        run_instr(7'b1101111, 3'd0, 7'd0, 0, 0, 0, 0, 1, 2, "jal", tp);
        run_instr(7'b1100111, 3'd0, 7'd0, 0, 0, 0, 0, 1, 2, "jalr", tp);
        run_instr(7'b0110111, 3'd0, 7'd0, 0, 0, 0, 0, 1, 2, "lui", tp);

        // Reset while IF is waiting on memory.
        op = 7'b0010011; mem_ready = 1'b0;
        step(exp_vec(P_IF, 1'b0, 1'b0, 1'b0, 2'b00), "if_wait");
        step(exp_vec(P_IF, 1'b0, 1'b0, 1'b0, 2'b00), "if_wait");
        do_reset("reset_midwait");

        run_instr(7'b1111111, 3'd0, 7'd0, 0, 0, 0, 0, 1, 20, "illegal", tp);
        do_reset("reset_trap");
        run_instr(7'b0010011, 3'd0, 7'd0, 0, 0, 0, 0, 1, 2, "addi_after_trap", tp);
        run_instr(7'b0010011, 3'd0, 7'd0, 0, 0, 4, 0, 1, 3, "timeout_if", tp);
        do_reset("reset_to_if");
        run_instr(7'b0000011, 3'd2, 7'd0, 0, 0, 3, 4, 1, 3, "timeout_lw", tp);
        do_reset("reset_to_lw");

        // Randomized instruction streams on each instance.
        for (int pass = 0; pass < 2; pass++) begin
            set_cfg(pass[0]);
            do_reset("reset_rand");
            for (int i = 0; i < 40; i++) begin
                int pick;
                logic [6:0] o;
                logic [6:0] f7;
                int wi, wm;
                pick = $urandom_range(0, 9);
                if (pick < 8) o = legal_ops[pick];
                else if (pick == 8) o = 7'b1111111;
                else o = 7'b0001111;
                f7 = ($urandom_range(0, 1) == 1) ? 7'b0000001 : 7'($urandom);
                wi = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3);
                wm = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
                run_instr(o, 3'($urandom), f7, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), wi, wm, $urandom_range(1, 6), 2,
                          "random", tp);
                if (tp) do_reset("reset_rand_trap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
